// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron membrane stage: widths, state
// encoding and the saturation helper applied to the adder result.
package lif_pkg;

  localparam int V_W   = 10;
  localparam int CNT_W = 4;
  localparam logic [V_W-1:0] V_MAX = 10'h3FF;

  typedef enum logic {
    INTEG   = 1'b0,
    REFRACT = 1'b1
  } lif_state_t;

  // Clamp an 11-bit sum to the 10-bit membrane range; the carry means overflow.
  function automatic logic [V_W-1:0] sat_sum(input logic [V_W:0] sum);
    logic [V_W-1:0] res;
    if (sum[V_W]) begin
      res = V_MAX;
    end else begin
      res = sum[V_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_10bit.sv
// Plain 10-bit unsigned adder with carry out; the sum is 11 bits wide so the
// caller can detect overflow.
module adder_10bit (
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic [10:0] c
);

  assign c = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/lif_membrane_ctrl.sv
// Sequential membrane stage of a leaky integrate-and-fire neuron. Leaks the
// held potential by a right shift, adds the synaptic input, saturates, fires
// on threshold and then clamps the potential to zero for a refractory window.
module lif_membrane_ctrl
  import lif_pkg::*;
#(
  parameter logic [9:0] THRESH      = 10'd512,
  parameter int         LEAK_SHIFT  = 3,
  parameter int         REFRACT_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        i_valid,
  input  logic [9:0]  i_syn,
  output logic [9:0]  v_mem,
  output logic        spike,
  output logic        refractory
);

  localparam bit HAS_REFRACT = (REFRACT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFRACT_CYC);

  lif_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [V_W-1:0]   v_r, v_nxt_s;
  logic             spike_r, spike_nxt_s;

  logic [V_W-1:0]   leak_v_s;
  logic [V_W-1:0]   syn_s;
  logic [V_W:0]     sum_s;
  logic [V_W-1:0]   sat_s;
  logic             fire_s;

  // Leak floors to zero for small V, so potentials below 2**LEAK_SHIFT persist.
  assign leak_v_s = v_r - (v_r >> LEAK_SHIFT);
  assign syn_s    = i_valid ? i_syn : 10'd0;

  adder_10bit u_add (
    .a (leak_v_s),
    .b (syn_s),
    .c (sum_s)
  );

  assign sat_s  = sat_sum(sum_s);
  assign fire_s = (sat_s >= THRESH);

  // State register: the FSM advances only on enabled edges (handled in next-state logic).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INTEG;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: fire enters refraction, counter expiry returns to integration.
  always_comb begin
    state_nxt_s = state_r;
    if (ena) begin
      case (state_r)
        INTEG: begin
          if (fire_s && HAS_REFRACT) begin
            state_nxt_s = REFRACT;
          end else begin
            state_nxt_s = INTEG;
          end
        end
        REFRACT: begin
          if (cnt_r == 4'd1) begin
            state_nxt_s = INTEG;
          end else begin
            state_nxt_s = REFRACT;
          end
        end
        default: state_nxt_s = INTEG;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output/datapath logic: next membrane value, spike request and refractory count.
  always_comb begin
    v_nxt_s     = v_r;
    cnt_nxt_s   = cnt_r;
    spike_nxt_s = 1'b0;
    if (ena) begin
      case (state_r)
        INTEG: begin
          if (fire_s) begin
            v_nxt_s     = 10'd0;
            spike_nxt_s = 1'b1;
            cnt_nxt_s   = CNT_LOAD;
          end else begin
            v_nxt_s     = sat_s;
          end
        end
        REFRACT: begin
          // Input during refraction is dropped, not accumulated.
          v_nxt_s   = 10'd0;
          cnt_nxt_s = cnt_r - 4'd1;
        end
        default: begin
          v_nxt_s   = 10'd0;
          cnt_nxt_s = 4'd0;
        end
      endcase
    end else begin
      v_nxt_s = v_r;
    end
  end

  // Datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r     <= 10'd0;
      cnt_r   <= 4'd0;
      spike_r <= 1'b0;
    end else begin
      v_r     <= v_nxt_s;
      cnt_r   <= cnt_nxt_s;
      spike_r <= spike_nxt_s;
    end
  end

  assign v_mem      = v_r;
  assign spike      = spike_r;
  assign refractory = (state_r == REFRACT);

endmodule

// File: tb/tb_lif_membrane_ctrl.sv
// Self-checking bench for lif_membrane_ctrl: a table of vectors replayed
// through a scoreboard queue, plus hand sequences for enable gating, async
// reset, and a second instance exercising saturation and REFRACT_CYC=0.
module tb_lif_membrane_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       i_valid = 1'b0;
  logic [9:0] i_syn = 10'd0;
  logic [9:0] v_mem;
  logic       spike;
  logic       refractory;

  logic       ena2 = 1'b0;
  logic       vld2 = 1'b0;
  logic [9:0] syn2 = 10'd0;
  logic [9:0] v2;
  logic       sp2;
  logic       rf2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [9:0] syn;
    logic [9:0] v;
    logic       sp;
    logic       rf;
  } vec_t;

  typedef struct {
    logic [9:0] v;
    logic       sp;
    logic       rf;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  lif_membrane_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .i_valid(i_valid), .i_syn(i_syn),
    .v_mem(v_mem), .spike(spike), .refractory(refractory)
  );

  lif_membrane_ctrl #(.THRESH(10'd1023), .LEAK_SHIFT(3), .REFRACT_CYC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .i_valid(vld2), .i_syn(syn2),
    .v_mem(v2), .spike(sp2), .refractory(rf2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One enabled/disabled cycle on the main DUT, checked through the scoreboard.
  task automatic step(input string name, input logic en, input logic vld,
                      input logic [9:0] syn, input logic [9:0] ev,
                      input logic esp, input logic erf);
    exp_t e;
    e.v = ev; e.sp = esp; e.rf = erf;
    sb.push_back(e);
    ena = en; i_valid = vld; i_syn = syn;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({name, " sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({name, " v_mem"}, int'(v_mem), int'(e.v));
      chk({name, " spike"}, int'(spike), int'(e.sp));
      chk({name, " refractory"}, int'(refractory), int'(e.rf));
    end
  endtask

  task automatic step2(input string name, input logic [9:0] syn,
                       input logic [9:0] ev, input logic esp);
    ena2 = 1'b1; vld2 = 1'b1; syn2 = syn;
    @(posedge clk);
    #1;
    chk({name, " v_mem"}, int'(v2), int'(ev));
    chk({name, " spike"}, int'(sp2), int'(esp));
    chk({name, " refractory"}, int'(rf2), 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    ena = 1'b0; i_valid = 1'b0; i_syn = 10'd0;
    #2;
    chk({name, " rst v_mem"}, int'(v_mem), 0);
    chk({name, " rst spike"}, int'(spike), 0);
    chk({name, " rst refractory"}, int'(refractory), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic r, input logic en, input logic vld,
                     input logic [9:0] syn, input logic [9:0] v,
                     input logic sp, input logic rf);
    vec_t t;
    t.rst = r; t.en = en; t.vld = vld; t.syn = syn; t.v = v; t.sp = sp; t.rf = rf;
    tbl.push_back(t);
  endtask

  initial begin
    // Decay: 100 leaks by V>>3 each idle cycle.
    add(1'b1, 1'b1, 1'b1, 10'd100, 10'd100, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 10'd0,   10'd88,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 10'd0,   10'd77,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 10'd0,   10'd68,  1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 10'd0,   10'd60,  1'b0, 1'b0);
    // Fire with 200 held: 200, 375, 529 -> spike, 4 refractory cycles, resume.
    add(1'b1, 1'b1, 1'b1, 10'd200, 10'd200, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'd200, 10'd375, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'd200, 10'd0,   1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, 10'd200, 10'd0,   1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 10'd200, 10'd0,   1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 10'd200, 10'd0,   1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 10'd200, 10'd0,   1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'd200, 10'd200, 1'b0, 1'b0);
    // Threshold boundary: 448+63=511 no fire, 448+64=512 fires.
    add(1'b1, 1'b1, 1'b1, 10'd511, 10'd511, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'd63,  10'd511, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'd64,  10'd0,   1'b1, 1'b1);
    // Overflow: 448+1023 carries out; wrapping would give 447 and no spike.
    add(1'b1, 1'b1, 1'b1, 10'd511, 10'd511, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 10'd1023, 10'd0,  1'b1, 1'b1);

    rst_n = 1'b0;
    #12;
    chk("power-on v_mem", int'(v_mem), 0);
    chk("power-on spike", int'(spike), 0);
    chk("power-on refractory", int'(refractory), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("vec%0d", i));
      step($sformatf("vec%0d", i), tbl[i].en, tbl[i].vld, tbl[i].syn,
           tbl[i].v, tbl[i].sp, tbl[i].rf);
    end

    // Enable gating: a disabled edge blocks firing, then freezes refraction.
    do_reset("gate");
    step("gate1", 1'b1, 1'b1, 10'd200, 10'd200, 1'b0, 1'b0);
    step("gate2", 1'b1, 1'b1, 10'd200, 10'd375, 1'b0, 1'b0);
    step("gate_hold_fire", 1'b0, 1'b1, 10'd200, 10'd375, 1'b0, 1'b0);
    step("gate_fire", 1'b1, 1'b1, 10'd200, 10'd0, 1'b1, 1'b1);
    step("gate_ref1", 1'b1, 1'b1, 10'd200, 10'd0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step($sformatf("gate_frozen%0d", k), 1'b0, 1'b1, 10'd200, 10'd0, 1'b0, 1'b1);
    end
    step("gate_ref2", 1'b1, 1'b1, 10'd200, 10'd0, 1'b0, 1'b1);
    step("gate_ref3", 1'b1, 1'b1, 10'd200, 10'd0, 1'b0, 1'b1);
    step("gate_ref_end", 1'b1, 1'b1, 10'd200, 10'd0, 1'b0, 1'b0);
    step("gate_resume", 1'b1, 1'b1, 10'd200, 10'd200, 1'b0, 1'b0);

    // Async reset while spike is high, with no clock edge in between.
    do_reset("arst");
    step("arst1", 1'b1, 1'b1, 10'd200, 10'd200, 1'b0, 1'b0);
    step("arst2", 1'b1, 1'b1, 10'd200, 10'd375, 1'b0, 1'b0);
    step("arst_fire", 1'b1, 1'b1, 10'd200, 10'd0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst mid v_mem", int'(v_mem), 0);
    chk("arst mid spike", int'(spike), 0);
    chk("arst mid refractory", int'(refractory), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("arst_after", 1'b1, 1'b1, 10'd7, 10'd7, 1'b0, 1'b0);

    // Second instance: THRESH=1023 lets V reach 900; REFRACT_CYC=0.
    do_reset("d2");
    step2("d2_900", 10'd900, 10'd900, 1'b0);
    step2("d2_sat", 10'd500, 10'd0, 1'b1);
    step2("d2_refire", 10'd1023, 10'd0, 1'b1);
    step2("d2_resume", 10'd100, 10'd100, 1'b0);

    chk("sb drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
